// File: rtl/vga_frame_analyzer.sv
// VGA receive-side frame analyzer: recovers line/frame timing, key-colour
// bounding box and timing lock from a raw HS/VS/blank_n/RGB pixel bus.
// Ports: vga_clk, reset (sync, active-low), HS, VS, blank_n, red/green/blue
// in; frame_valid, h_total, v_total, h_active, v_active, box_found,
// box_x0/y0/x1/y1, locked, sync_lost out (all registered).
module vga_frame_analyzer #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int KEY_THRESH      = 128,
  parameter int LOCK_FRAMES     = 3,
  parameter int TIMEOUT         = 1048576
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        frame_valid,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] h_active,
  output logic [10:0] v_active,
  output logic        box_found,
  output logic [10:0] box_x0,
  output logic [10:0] box_y0,
  output logic [10:0] box_x1,
  output logic [10:0] box_y1,
  output logic        locked,
  output logic        sync_lost
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0] CMAX = 11'h7ff;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CMAX) ? v : v + 11'd1;
  endfunction

  state_t          st;
  logic            hs1, vs1, bl1, hs2, vs2;
  logic [7:0]      r1, g1, b1;
  logic [10:0]     h_cnt, line_len, x, y, v_cnt, last_h_act;
  logic            line_act;
  logic            found;
  logic [10:0]     kx0, ky0, kx1, ky1;
  logic [TW-1:0]   to_cnt;
  logic [MW-1:0]   match_cnt;

  logic            hs_edge, vs_edge, key, timeout, same, lock_hit;
  logic [10:0]     line_len_n, v_cnt_n, y_n, last_h_n;
  logic            found_n;
  logic [10:0]     kx0_n, ky0_n, kx1_n, ky1_n;
  logic [MW-1:0]   mc_next;

  // Asserted level: XOR with the polarity flag turns active-low into high.
  assign hs_edge = (hs1 ^ SYNC_ACTIVE_LOW) & ~(hs2 ^ SYNC_ACTIVE_LOW);
  assign vs_edge = (vs1 ^ SYNC_ACTIVE_LOW) & ~(vs2 ^ SYNC_ACTIVE_LOW);
  assign key = bl1 && (int'(r1) >= KEY_THRESH)
            && (int'(g1) < KEY_THRESH) && (int'(b1) < KEY_THRESH);
  assign timeout = !vs_edge && (to_cnt == TW'(TIMEOUT - 1));

  // Next-state view of the frame accumulators, so a line ending on the
  // same cycle as VS is folded in before the frame is published.
  always_comb begin
    line_len_n = line_len;
    v_cnt_n    = v_cnt;
    y_n        = y;
    last_h_n   = last_h_act;
    if (hs_edge) begin
      line_len_n = sat_inc(h_cnt);
      v_cnt_n    = sat_inc(v_cnt);
      if (line_act) begin
        last_h_n = x;
        y_n      = sat_inc(y);
      end
    end
    found_n = found;
    kx0_n   = kx0;
    ky0_n   = ky0;
    kx1_n   = kx1;
    ky1_n   = ky1;
    if (key) begin
      found_n = 1'b1;
      if (!found || x < kx0) kx0_n = x;
      if (!found || y < ky0) ky0_n = y;
      if (!found || x > kx1) kx1_n = x;
      if (!found || y > ky1) ky1_n = y;
    end
    same = (line_len_n == h_total) && (v_cnt_n == v_total);
    if (!same)
      mc_next = MW'(1);
    else if (match_cnt >= MW'(LOCK_FRAMES))
      mc_next = match_cnt;
    else
      mc_next = match_cnt + MW'(1);
    lock_hit = (mc_next >= MW'(LOCK_FRAMES));
  end

  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      st <= SEARCH;
      {hs1, vs1, bl1, hs2, vs2} <= '0;
      {r1, g1, b1} <= '0;
      h_cnt <= '0; line_len <= '0; x <= '0; y <= '0;
      v_cnt <= '0; last_h_act <= '0; line_act <= 1'b0;
      found <= 1'b0;
      {kx0, ky0, kx1, ky1} <= '0;
      to_cnt <= '0; match_cnt <= '0;
      frame_valid <= 1'b0;
      h_total <= '0; v_total <= '0;
      h_active <= '0; v_active <= '0;
      box_found <= 1'b0;
      {box_x0, box_y0, box_x1, box_y1} <= '0;
      locked <= 1'b0; sync_lost <= 1'b0;
    end else begin
      hs1 <= HS; vs1 <= VS; bl1 <= blank_n;
      r1 <= red; g1 <= green; b1 <= blue;
      hs2 <= hs1; vs2 <= vs1;
      h_cnt    <= hs_edge ? 11'd0 : sat_inc(h_cnt);
      line_len <= line_len_n;
      x        <= hs_edge ? 11'd0 : (bl1 ? sat_inc(x) : x);
      line_act <= hs_edge ? 1'b0 : (line_act | bl1);
      frame_valid <= 1'b0;
      if (vs_edge || timeout) begin
        y <= '0; v_cnt <= '0; last_h_act <= '0;
        found <= 1'b0;
        {kx0, ky0, kx1, ky1} <= '0;
        to_cnt <= '0;
      end else begin
        y <= y_n; v_cnt <= v_cnt_n; last_h_act <= last_h_n;
        found <= found_n;
        kx0 <= kx0_n; ky0 <= ky0_n; kx1 <= kx1_n; ky1 <= ky1_n;
        to_cnt <= to_cnt + TW'(1);
      end
      if (timeout) begin
        st <= SEARCH;
        match_cnt <= '0;
        locked <= 1'b0;
        sync_lost <= 1'b1;
      end else if (vs_edge) begin
        if (st == SEARCH) begin
          st <= MEASURE;
          match_cnt <= '0;
        end else begin
          frame_valid <= 1'b1;
          h_total  <= line_len_n;
          v_total  <= v_cnt_n;
          h_active <= last_h_n;
          v_active <= y_n;
          box_found <= found_n;
          box_x0 <= found_n ? kx0_n : 11'd0;
          box_y0 <= found_n ? ky0_n : 11'd0;
          box_x1 <= found_n ? kx1_n : 11'd0;
          box_y1 <= found_n ? ky1_n : 11'd0;
          unique case (st)
            MEASURE: begin
              match_cnt <= mc_next;
              if (lock_hit) begin
                st <= LOCKED;
                locked <= 1'b1;
              end
            end
            default: begin
              if (!same) begin
                st <= MEASURE;
                match_cnt <= MW'(1);
                locked <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/vga_frame_analyzer.md
Name: vga_frame_analyzer

Overview:
- Receive-side companion to the team's VGA sync/pixel generator. Samples the raw VGA bus (HS, VS, blank_n, 8-bit RGB) on the pixel clock.
- Recovers per-frame timing: total and active line and frame sizes.
- Tracks the bounding box of key-coloured pixels and reports lock status.
- Used as an on-chip loopback checker and as the capture front end for downstream video processing.

Parameters:
SYNC_ACTIVE_LOW, 1, HS/VS asserted level is 0 when 1, 1 when 0
KEY_THRESH, 128, colour channel threshold for key-pixel match
LOCK_FRAMES, 3, consecutive identical-timing frames required to assert locked
TIMEOUT, 1048576, vga_clk cycles without a VS leading edge before lock is dropped

Ports:
vga_clk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
HS  in  1  horizontal sync
VS  in  1  vertical sync
blank_n  in  1  high = active video
red  in  8  pixel red
green  in  8  pixel green
blue  in  8  pixel blue
frame_valid  out  1  one-cycle pulse, published fields updated
h_total  out  11  clocks per line (last complete line)
v_total  out  11  lines per frame
h_active  out  11  active pixels in last active line
v_active  out  11  lines containing >=1 active pixel
box_found  out  1  >=1 key pixel seen in last frame
box_x0  out  11  min key x
box_y0  out  11  min key y
box_x1  out  11  max key x
box_y1  out  11  max key y
locked  out  1  timing stable
sync_lost  out  1  sticky, set on timeout, cleared by reset

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0, all counters 0, FSM to SEARCH. Reset is synchronous and active-low.
- Input stage: all inputs registered once (s1), with a second sync-only register (s2).
- Sync edges: HS edge = s1 HS asserted and s2 HS deasserted (assertion level per SYNC_ACTIVE_LOW). VS edge is defined the same way.
- h_cnt: increments every cycle, saturating at 2047. On an HS edge:
  - line_len <= h_cnt + 1 (saturating), then h_cnt <= 0.
  - If the line had an active pixel: last_h_act <= x, y <= y + 1.
- x: coordinate of the current active pixel. First active pixel of a line is x=0. Increments after each sample with blank_n=1 and resets on an HS edge.
- y: number of completed active lines in the current frame, so the first active line is y=0. Resets on a VS edge.
- v_cnt: counts HS edges in the interval (previous VS edge, current VS edge]. An HS edge coincident with the VS edge is counted and its line is finalised first.
- Key pixel: blank_n=1, red >= KEY_THRESH, green < KEY_THRESH and blue < KEY_THRESH. Each key pixel updates min/max x/y using its own x and y.
- VS edge sampled into s1 at edge k:
  - At edge k+1, publish h_total, v_total, h_active, v_active and the box fields.
  - frame_valid is high for the cycle after edge k+1.
  - Frame accumulators clear at the same time.
  - Box coordinates publish as 0 when box_found=0.
- First VS edge after reset or SEARCH: only starts a frame. Nothing is published and frame_valid stays 0.
- Lock FSM:
  - SEARCH -> MEASURE on a VS edge.
  - In MEASURE, at each publish: if (h_total, v_total) equals the previous published pair, match_cnt++; otherwise match_cnt <= 1.
  - When match_cnt reaches LOCK_FRAMES: go to LOCKED and set locked=1.
  - LOCKED: on a mismatching publish, locked=0, go to MEASURE, match_cnt <= 1.
- Timeout: in any state, if TIMEOUT cycles pass with no VS edge:
  - locked=0, sync_lost=1.
  - Go to SEARCH and discard the partial frame.
  - Published fields hold their last values.
- Saturation: all 11-bit counters saturate at 2047 and never wrap.

Test Plan:
- 640x480 timing (800x525, HS 96 clocks, VS 2 lines, negative sync), blue background, red square x 100..200 and y 100..200, four frames:
  - Published values: h_total=800, v_total=525, h_active=640, v_active=480.
  - Box: box 100,100,200,200, box_found=1.
  - Lock: locked=1 after the publish that completes LOCK_FRAMES matches.
- Sync timing: frame_valid pulses exactly 2 clocks after VS is first sampled asserted and is never asserted for the first VS after reset.
- Timing change: with locked=1, switch to h_total 810 for one frame. Then locked=0 at that publish, and locked=1 again after 3 more matching frames.
- Blank frame: all-blue frame gives box_found=0 with box fields 0.
- Edge-aligned key pixels: single key pixels at (0,0) and (639,479) give box 0,0,639,479.
- Timeout and mid-frame reset:
  - Stop VS (hold deasserted) for TIMEOUT+1 cycles: sync_lost=1, locked=0. Resume frames and locked returns.
  - Assert reset mid-frame: all outputs 0 on the next edge, and no publish until the second VS edge after release.
